serial_add_sub16: RTL and testbench

Bit-serial 16-bit adder/subtractor with a start/done handshake. It is the sequential counterpart of the combinational 16-bit ripple adder: it accepts operands A, B, carry-in Ci and an operation select, and produces the sum or difference one bit per clock through a single 1-bit full adder. Results are held in registers for a consuming controller or bench. The block trades latency for area, and also gives the combinational adder a cycle-accurate reference for cross-checking.

---
 rtl/serial_add_sub_pkg.sv | 14 +
 rtl/full_adder_1.sv | 13 +
 rtl/serial_add_sub16.sv | 147 ++++++++++++++
 tb/tb_serial_add_sub16.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// The optional overflow flag is enabled by defining OVF_FLAG_EN.
package serial_add_sub_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_1.sv
// Single-bit combinational full adder used by the serial datapath.
module full_adder_1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub16.sv
// Bit-serial WIDTH-bit adder/subtractor with start/done handshake.
// Define OVF_FLAG_EN to compute the signed overflow flag V; otherwise V is tied to 0.
module serial_add_sub16
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             Sub,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_s, fa_co;
`ifdef OVF_FLAG_EN
    logic             v_q, v_d;
`endif

    full_adder_1 u_fa (
        .a  (a_q[0]),
        .b  (b_q[0] ^ sub_q),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OVF_FLAG_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef OVF_FLAG_EN
            v_q     <= v_d;
`endif
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        co_d    = co_q;
`ifdef OVF_FLAG_EN
        v_d     = v_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = Sub;
                    carry_d = Ci ^ Sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                // Results load on the final bit so they are visible throughout DONE
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    s_d     = {fa_s, res_q[WIDTH-1:1]};
                    co_d    = fa_co;
`ifdef OVF_FLAG_EN
                    v_d     = carry_q ^ fa_co;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign S    = s_q;
    assign Co   = co_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef OVF_FLAG_EN
    assign V    = v_q;
`else
    assign V    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub16.sv
// Directed self-checking bench for serial_add_sub16 using immediate assertions.
module tb_serial_add_sub16;

    localparam int unsigned W = 16;

`ifdef OVF_FLAG_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ci;
    logic         Sub;
    logic [W-1:0] S;
    logic         Co;
    logic         V;
    logic         busy;
    logic         done;

    int n_asserts;
    int n_fail;

    serial_add_sub16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .Sub   (Sub),
        .S     (S),
        .Co    (Co),
        .V     (V),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Call at a negedge; returns at the next negedge after the done pulse has ended.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub,
                          input logic [W-1:0] es, input logic eco, input logic ev);
        int  n;
        int  overlap;
        bit  seen;
        A     = a;
        B     = b;
        Ci    = ci;
        Sub   = sub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = ~a;
        B     = ~b;
        Ci    = ~ci;
        Sub   = ~sub;
        check({tag, "_busy_on"}, 32'(busy), 32'(1));
        n       = 0;
        overlap = 0;
        seen    = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy && done) overlap++;
            if (done) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_S"}, 32'(S), 32'(es));
        check({tag, "_Co"}, 32'(Co), 32'(eco));
        check({tag, "_V"}, 32'(V), 32'(ev));
        check({tag, "_busy_off"}, 32'(busy), 32'(0));
        check({tag, "_overlap"}, 32'(overlap), 32'(0));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'(0));
        check({tag, "_S_hold"}, 32'(S), 32'(es));
        @(negedge clk);
    endtask

    initial begin
        int          dones;
        logic [W-1:0] s_cap;
        logic [W-1:0] iv;
        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        A         = '0;
        B         = '0;
        Ci        = 1'b0;
        Sub       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_S", 32'(S), 32'(0));
        check("rst_Co", 32'(Co), 32'(0));
        check("rst_V", 32'(V), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
        run_op("sub_brw",   16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
        run_op("add_ci",    16'h00FF, 16'h0100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0);

        for (int i = 0; i < 32; i++) begin
            iv = W'(i);
            run_op($sformatf("sweep%0d", i), iv, iv, iv[0], 1'b0,
                   W'(2 * i + (i % 2)), 1'b0, 1'b0);
        end

        // start pulses during SHIFT must be ignored
        A     = 16'h1234;
        B     = 16'h4321;
        Ci    = 1'b0;
        Sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        s_cap = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = (n == 3 || n == 10);
            A     = 16'hAAAA;
            B     = 16'h0F0F;
            Sub   = 1'b1;
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                s_cap = S;
            end
        end
        start = 1'b0;
        check("ignore_done_count", 32'(dones), 32'(1));
        check("ignore_S", 32'(s_cap), 32'(16'h5555));
        check("ignore_idle", 32'(busy), 32'(0));

        // reset asserted during the 8th SHIFT cycle
        @(negedge clk);
        A     = 16'hFFFF;
        B     = 16'h0001;
        Ci    = 1'b0;
        Sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'(1));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_S", 32'(S), 32'(0));
        check("midrst_Co", 32'(Co), 32'(0));
        check("midrst_V", 32'(V), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
